// File: rtl/enc_pkg.sv
// Shared constants for the spike encoder: mode codes,
// FSM state encoding and LFSR taps.
package enc_pkg;

  localparam logic [1:0] ENC_RATE = 2'd0;
  localparam logic [1:0] ENC_THR  = 2'd1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/spike_enc_engine_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and
// per-cycle advance enable.
module lfsr16
  import enc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (adv) begin
      state_d = {1'b0, state_q[15:1]}
              ^ (state_q[0] ? LFSR_TAPS : 16'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/spike_enc_engine.sv
// Pixel-to-spike encoder: streams frames from pixel SRAM,
// rate/threshold codes each pixel and packs spike words.
module spike_enc_engine
  import enc_pkg::*;
#(
  parameter int          PIX_N     = 784,
  parameter int          PIX_W     = 8,
  parameter int          T_STEPS   = 8,
  parameter int          SPK_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int WPS  = (PIX_N + SPK_W - 1) / SPK_W,
  localparam int PA_W = $clog2(PIX_N),
  localparam int SA_W = $clog2(T_STEPS * WPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_start,
  input  logic [1:0]       enc_sel,
  input  logic [PIX_W-1:0] enc_thr,
  output logic             enc_busy,
  output logic             enc_done,
  output logic             pix_rd_en,
  output logic [PA_W-1:0]  pix_addr,
  input  logic [PIX_W-1:0] pix_rdata,
  output logic             spk_wr_en,
  output logic [SA_W-1:0]  spk_addr,
  output logic [SPK_W-1:0] spk_wdata
);

  localparam int TS_W = $clog2(T_STEPS + 1);
  localparam int BW   = $clog2(SPK_W);

  logic [2:0]       state_q, state_d;
  logic [PA_W-1:0]  addr_q, addr_d;
  logic [TS_W-1:0]  step_q, step_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             thr_mode_q, thr_mode_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [SPK_W-1:0] sr_q, sr_d;
  logic [SA_W-1:0]  wa_q, wa_d;
  logic             wr_q, wr_d;
  logic [SA_W-1:0]  sa_q, sa_d;
  logic [SPK_W-1:0] wd_q, wd_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [15:0]      lfsr_s;
  logic             run;
  logic             abort;
  logic             last_rd;
  logic             spike;
  logic [SPK_W-1:0] word;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .seed  (LFSR_SEED),
    .state (lfsr_s)
  );

  assign run       = (state_q == S_RUN);
  assign abort     = !enc_start
                   && (run || state_q == S_DRAIN);
  assign last_rd   = (addr_q == PA_W'(PIX_N - 1))
                   && (step_q == TS_W'(T_STEPS - 1));
  assign spike     = thr_mode_q
                   ? (pix_rdata >= thr_q)
                   : (pix_rdata > lfsr_s[PIX_W-1:0]);
  assign word      = sr_q | (SPK_W'(spike) << bit_q);
  assign lfsr_adv  = vld_q && !thr_mode_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    step_d     = step_q;
    thr_mode_d = thr_mode_q;
    thr_d      = thr_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    wa_d       = wa_q;
    sa_d       = sa_q;
    wd_d       = wd_q;
    wr_d       = 1'b0;
    lfsr_load  = 1'b0;
    vld_d      = run && !abort;
    last_d     = (addr_q == PA_W'(PIX_N - 1));

    // Returned pixel: pack, and flush at word or step end
    if (vld_q && !abort) begin
      if (bit_q == BW'(SPK_W - 1) || last_q) begin
        wr_d  = 1'b1;
        sa_d  = wa_q;
        wd_d  = word;
        wa_d  = wa_q + 1'b1;
        bit_d = '0;
        sr_d  = '0;
      end else begin
        sr_d  = word;
        bit_d = bit_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (enc_start) begin
          state_d    = S_RUN;
          thr_mode_d = (enc_sel == ENC_THR);
          thr_d      = enc_thr;
          lfsr_load  = 1'b1;
          addr_d     = '0;
          step_d     = '0;
          bit_d      = '0;
          sr_d       = '0;
          wa_d       = '0;
        end
      end
      S_RUN: begin
        if (addr_q == PA_W'(PIX_N - 1)) begin
          addr_d = '0;
          step_d = step_q + 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!vld_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: begin
        if (!enc_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      step_d  = '0;
      bit_d   = '0;
      sr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      step_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      thr_mode_q <= 1'b0;
      thr_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      wa_q       <= '0;
      wr_q       <= 1'b0;
      sa_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      thr_mode_q <= thr_mode_d;
      thr_q      <= thr_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      wa_q       <= wa_d;
      wr_q       <= wr_d;
      sa_q       <= sa_d;
      wd_q       <= wd_d;
    end
  end

  assign enc_busy  = run || (state_q == S_DRAIN)
                   || (state_q == S_DONE);
  assign enc_done  = (state_q == S_DONE);
  assign pix_rd_en = run;
  assign pix_addr  = addr_q;
  assign spk_wr_en = wr_q;
  assign spk_addr  = sa_q;
  assign spk_wdata = wd_q;

endmodule

// File: tb/tb_spike_enc_engine.sv
// Bench for spike_enc_engine: small-frame instance checked
// against a frame-level model, plus a default-size instance.
module tb_spike_enc_engine;

  localparam int S_PIX = 40;
  localparam int S_SPK = 32;
  localparam int S_T   = 2;
  localparam int S_N   = S_PIX * S_T;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- small instance ----------------
  logic        rst_n = 1'b0;
  logic        enc_start = 1'b0;
  logic [1:0]  enc_sel = 2'd0;
  logic [7:0]  enc_thr = 8'd0;
  logic        enc_busy, enc_done, pix_rd_en;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_rdata = 8'd0;
  logic        spk_wr_en;
  logic [1:0]  spk_addr;
  logic [31:0] spk_wdata;

  spike_enc_engine #(
    .PIX_N(S_PIX), .PIX_W(8), .T_STEPS(S_T),
    .SPK_W(S_SPK), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .enc_start(enc_start), .enc_sel(enc_sel),
    .enc_thr(enc_thr), .enc_busy(enc_busy),
    .enc_done(enc_done), .pix_rd_en(pix_rd_en),
    .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .spk_wr_en(spk_wr_en), .spk_addr(spk_addr),
    .spk_wdata(spk_wdata)
  );

  logic [7:0] mem [S_PIX];

  always @(posedge clk)
    if (pix_rd_en) pix_rdata <= mem[pix_addr];

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  ticks = 0;
  int  base = 0;
  bit  active = 0;
  int  abort_at = 0;

  always @(posedge clk) ticks <= ticks + 1;

  function automatic logic [15:0] lfsr_step(
      input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Frame-level model: walk every (step, pixel), apply the
  // spike rule, group into words and note their write cycle.
  task automatic build(input bit thr_mode,
                       input logic [7:0] thr,
                       input int abort);
    logic [15:0] l;
    logic [31:0] w;
    bit          s;
    int          rc;
    wr_t         e;
    l = 16'hACE1;
    exp_q.delete();
    for (int t = 0; t < S_T; t++) begin
      w = 32'h0;
      for (int i = 0; i < S_PIX; i++) begin
        rc = t * S_PIX + i + 1;
        if (thr_mode) s = (mem[i] >= thr);
        else begin
          s = (mem[i] > l[7:0]);
          l = lfsr_step(l);
        end
        if (s) w = w | (32'h1 << (i % S_SPK));
        if ((i % S_SPK) == S_SPK - 1 || i == S_PIX - 1) begin
          e.cyc  = rc + 2;
          e.addr = t * 2 + i / S_SPK;
          e.data = w;
          if (abort == 0 || e.cyc <= abort) exp_q.push_back(e);
          w = 32'h0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    int  c;
    int  lim;
    bit  exp_rd;
    wr_t e;
    if (active) begin
      c   = ticks - base;
      lim = (abort_at > 0) ? abort_at : S_N;
      exp_rd = (c >= 1 && c <= lim);
      chk("pix_rd_en", pix_rd_en, exp_rd);
      if (exp_rd && pix_rd_en)
        chk("pix_addr", pix_addr, (c - 1) % S_PIX);
      if (abort_at > 0) begin
        chk("enc_busy", enc_busy, c >= 1 && c <= abort_at);
        chk("enc_done", enc_done, 0);
      end else begin
        chk("enc_busy", enc_busy, c >= 1 && c <= S_N + 3);
        chk("enc_done", enc_done, c == S_N + 3);
      end
      if (spk_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", c, e.cyc);
          chk("spk_addr", spk_addr, e.addr);
          chk("spk_wdata", spk_wdata, e.data);
        end
      end
    end
  end

  task automatic run_small(input logic [1:0] sel,
                           input logic [7:0] thr,
                           input int abort,
                           input int hold);
    @(negedge clk);
    enc_sel   = sel;
    enc_thr   = thr;
    enc_start = 1'b1;
    abort_at  = abort;
    base      = ticks;
    active    = 1;
    while (ticks - base < 2) @(negedge clk);
    enc_sel = sel ^ 2'd1;
    enc_thr = ~thr;
    if (abort > 0) begin
      while (ticks - base < abort) @(negedge clk);
      enc_start = 1'b0;
      while (ticks - base < abort + 10) @(negedge clk);
    end else begin
      while (ticks - base < S_N + 3 + hold) @(negedge clk);
      enc_start = 1'b0;
      while (ticks - base < S_N + 6 + hold) @(negedge clk);
    end
    active = 0;
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- default-size instance ----------------
  logic        rst_b_n = 1'b0;
  logic        start_b = 1'b0;
  logic        busy_b, done_b, rd_b, wr_b;
  logic [9:0]  paddr_b;
  logic [7:0]  rdata_b = 8'd0;
  logic [7:0]  saddr_b;
  logic [31:0] wdata_b;

  spike_enc_engine u_big (
    .clk(clk), .rst_n(rst_b_n),
    .enc_start(start_b), .enc_sel(2'd1),
    .enc_thr(8'd0), .enc_busy(busy_b),
    .enc_done(done_b), .pix_rd_en(rd_b),
    .pix_addr(paddr_b), .pix_rdata(rdata_b),
    .spk_wr_en(wr_b), .spk_addr(saddr_b),
    .spk_wdata(wdata_b)
  );

  always @(posedge clk)
    if (rd_b) rdata_b <= 8'hFF;

  task automatic run_big();
    int  nw;
    bit  got_done;
    @(negedge clk);
    start_b = 1'b1;
    repeat (500) @(posedge clk);
    #1 rst_b_n = 1'b0;
    #1;
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_rd_en", rd_b, 0);
    chk("rst_pix_addr", paddr_b, 0);
    chk("rst_wr_en", wr_b, 0);
    chk("rst_spk_addr", saddr_b, 0);
    chk("rst_wdata", wdata_b, 0);
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    nw = 0;
    got_done = 0;
    @(posedge clk);
    for (int c = 1; c <= 6300; c++) begin
      @(negedge clk);
      if (wr_b) begin
        chk("big_addr", saddr_b, nw);
        chk("big_data", wdata_b,
            (nw % 25 == 24) ? 32'h0000FFFF : 32'hFFFFFFFF);
        nw++;
      end
      if (done_b) begin
        chk("big_done_cycle", c, 6275);
        got_done = 1;
        start_b = 1'b0;
      end
    end
    chk("big_writes", nw, 200);
    chk("big_done_seen", got_done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", enc_busy, 0);
    chk("rst_done", enc_done, 0);
    chk("rst_rd_en", pix_rd_en, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_wr_en", spk_wr_en, 0);
    chk("rst_spk_addr", spk_addr, 0);
    chk("rst_wdata", spk_wdata, 0);
    rst_n = 1'b1;
    rst_b_n = 1'b1;

    // threshold, flat 0x80 >= 0x80
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'h80;
    build(1, 8'h80, 0);
    chk("model_w0", exp_q[0].data, 32'hFFFFFFFF);
    chk("model_w1", exp_q[1].data, 32'h000000FF);
    chk("model_w3", exp_q[3].data, 32'h000000FF);
    chk("model_a2", exp_q[2].addr, 2);
    chk("model_done_cyc", exp_q[3].cyc + 1, 83);
    run_small(2'd1, 8'h80, 0, 0);

    // rate, zero pixels never spike
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'h00;
    build(0, 8'h00, 0);
    chk("model_zero", exp_q[2].data, 32'h0);
    run_small(2'd0, 8'h00, 0, 0);

    // rate (sel 2 aliases rate), full-scale pixels
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'hFF;
    build(0, 8'h00, 0);
    run_small(2'd2, 8'h00, 0, 0);

    // threshold ramp i*6 >= 0x78
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'(i * 6);
    build(1, 8'h78, 0);
    chk("model_ramp_w0", exp_q[0].data, 32'hFFF00000);
    chk("model_ramp_w1", exp_q[1].data, 32'h000000FF);
    run_small(2'd1, 8'h78, 0, 0);

    // rate ramp twice: start held after done, then rerun
    build(0, 8'h00, 0);
    run_small(2'd3, 8'h00, 0, 5);
    build(0, 8'h00, 0);
    run_small(2'd0, 8'h00, 0, 0);

    // abort at cycle 30, then a clean job
    for (int i = 0; i < S_PIX; i++) mem[i] = 8'h80;
    build(1, 8'h80, 30);
    run_small(2'd1, 8'h80, 30, 0);
    build(1, 8'h80, 0);
    run_small(2'd1, 8'h80, 0, 0);

    run_big();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spike_enc_engine.md
# spike_enc_engine

Hardware encoder that answers the control FSM's `enc_start`/`enc_done` handshake: the responder end of the encode-stage protocol. While started, it streams `PIX_N` pixels from the pixel SRAM for each of `T_STEPS` timesteps and converts each pixel to a spike bit, by rate (LFSR) or threshold coding. It packs the spike bits into `SPK_W`-bit words, writes them to the spike buffer consumed by the SNN core, and pulses `enc_done` once all writes have completed.

## Interface
Parameters:
- `PIX_N`, 784: pixels per frame.
- `PIX_W`, 8: pixel width.
- `T_STEPS`, 8: timesteps per job.
- `SPK_W`, 32: spike bits per buffer word.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR seed.

Derived constants: `WPS = ceil(PIX_N/SPK_W)` words per step; `PA_W = clog2(PIX_N)`; `SA_W = clog2(T_STEPS*WPS)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enc_start`  in  1  level from the control FSM, held high until it sees `enc_done`.
- `enc_sel`  in  2  mode, sampled at job start: 0 = rate, 1 = threshold, 2/3 = treated as rate.
- `enc_thr`  in  PIX_W  threshold, sampled at job start.
- `enc_busy`  out  1  job in progress.
- `enc_done`  out  1  single-cycle completion pulse.
- `pix_rd_en`  out  1  pixel SRAM read strobe.
- `pix_addr`  out  PA_W  pixel index.
- `pix_rdata`  in  PIX_W  valid the cycle after `pix_rd_en` (sync SRAM).
- `spk_wr_en`  out  1  spike buffer write strobe.
- `spk_addr`  out  SA_W  word address = t*WPS + word index.
- `spk_wdata`  out  SPK_W  packed spike word.

## Operation
- States:
  - IDLE: `enc_start` high → latch mode and threshold, reload LFSR with `LFSR_SEED`, clear counters → RUN.
  - RUN: issue one read per cycle, `pix_addr` 0..PIX_N-1 and wrapping to 0 for each t, T_STEPS*PIX_N reads back-to-back → DRAIN.
  - DRAIN: finish the final word write → DONE.
  - DONE: `enc_done`=1 for one cycle → WAIT_REL.
  - WAIT_REL: stay until `enc_start`=0 → IDLE. This stops a re-trigger, because start is still high on the edge that samples `enc_done`.
- Spike rule, evaluated on returned data:
  - Threshold mode: spike = `pix_rdata >= thr`.
  - Rate mode: spike = `pix_rdata > lfsr[PIX_W-1:0]`, so pixel 0 never spikes.
- LFSR: 16-bit Galois, taps 0xB400. Advances once per returned pixel in rate mode only.
- Packing:
  - Pixel i of step t goes to bit `i % SPK_W` of word `i / SPK_W`, LSB first.
  - The last word of a step is written when pixel PIX_N-1 returns; its unused upper bits are 0.
  - The shift register clears at each word boundary.
- Abort: `enc_start` falls in RUN or DRAIN → IDLE next edge. No further writes, no `enc_done`.

## Timing
- Start sampled at edge E0 → `pix_rd_en` high in cycles 1..T_STEPS*PIX_N, continuously with no gaps between steps.
- A word's `spk_wr_en` is high 2 cycles after the `pix_rd_en` of its last pixel; `spk_addr`/`spk_wdata` are registered and valid with it.
- Final write is in cycle T_STEPS*PIX_N+2; `enc_done` is in cycle T_STEPS*PIX_N+3.
- `enc_busy` is high from cycle 1 through the `enc_done` cycle, and low in WAIT_REL.
- Reset, at any time including mid-job: state IDLE, LFSR = seed, all counters 0. All outputs are 0: `enc_busy`, `enc_done`, `pix_rd_en`, `pix_addr`, `spk_wr_en`, `spk_addr`, `spk_wdata`.
- `enc_sel`/`enc_thr` changes after E0 are ignored until the next job.
- Exactly T_STEPS*WPS writes per completed job.

## Structure
- Shared package `enc_pkg` holds:
  - mode codes `ENC_RATE`=2'd0 and `ENC_THR`=2'd1;
  - state encoding IDLE/RUN/DRAIN/DONE/WAIT_REL;
  - the LFSR tap constant 16'hB400.
- One sub-module, `lfsr16`, with ports seed load, advance enable and 16-bit state out.
- The rest is a single module: FSM, read-address/step counters, 1-cycle valid pipe, bit packer, write register.

## Test plan
Scenarios 1–5 use PIX_N=40, SPK_W=32, T_STEPS=2, so WPS=2.
1. Threshold mode, all pixels 0x80, thr 0x80 → 4 writes to addresses 0,1,2,3 with data 0xFFFFFFFF, 0x000000FF, 0xFFFFFFFF, 0x000000FF; `enc_done` in cycle 83.
2. Rate mode, all pixels 0x00 → 4 writes, all data 0. Same mode with all pixels 0xFF → each bit matches a reference model using LFSR seed 0xACE1.
3. Threshold mode, pixel i = i*6, thr 0x78 → word0 = 0xFFF00000 (bits 20..31 set), word1 = 0xFF.
4. Hold `enc_start` high for 5 cycles after `enc_done` → no new `pix_rd_en`. Drop start, then raise it again → second job starts the cycle after it is sampled, with the LFSR reseeded and output identical to the first job.
5. Drop `enc_start` at cycle 30 → `pix_rd_en`/`spk_wr_en` low from cycle 31, no `enc_done`, state IDLE.
6. Default params, threshold mode, all pixels 0xFF, thr 0, with `rst_n` pulsed low at cycle 500 → all outputs 0 asynchronously. A restarted job gives 200 writes; the last word per step is 0x0000FFFF and the others are 0xFFFFFFFF.
